// File: rtl/char_ram_pkg.sv
// char_ram_pkg: shared constants and types for the character RAM arbiter
package char_ram_pkg;
    localparam int RAM_BITS = 13;
    localparam int NUM_COLS = 80;
    localparam int NUM_ROWS = 80;
    localparam int RAM_WORDS = NUM_COLS * NUM_ROWS;
    localparam logic [7:0] FILL_CHAR = 8'h20;
    localparam int ENTRY_W = RAM_BITS + 8;
    typedef enum logic {
        S_IDLE = 1'b0,
        S_CLEAR = 1'b1
    } clr_state_t;
endpackage

// File: rtl/char_wr_fifo.sv
// char_wr_fifo: synchronous show-ahead FIFO buffering UART writes
module char_wr_fifo #(
    parameter int W = 21,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic         o_empty,
    output logic         o_full
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0] r_wp;
    logic [AW:0] r_rp;
    logic w_push_ok;
    logic w_pop_ok;
    assign o_empty = r_wp == r_rp;
    assign o_full = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_pop_ok = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);
    assign o_head = r_mem[r_rp[AW-1:0]];
    // pointer update; a pop frees the slot a simultaneous push lands in
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_push_ok) r_wp <= r_wp + 1'b1;
            if (w_pop_ok) r_rp <= r_rp + 1'b1;
        end
    end
    // storage write, no reset needed since pointers guard validity
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wp[AW-1:0]] <= i_din;
    end
endmodule

// File: rtl/char_ram_arbiter.sv
// char_ram_arbiter: shares the character RAM between video, clear engine and UART writes
module char_ram_arbiter #(
    parameter int RAM_BITS = char_ram_pkg::RAM_BITS,
    parameter int RAM_WORDS = char_ram_pkg::RAM_WORDS,
    parameter int FIFO_DEPTH = 4,
    parameter logic [7:0] FILL_CHAR = char_ram_pkg::FILL_CHAR
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [RAM_BITS-1:0] i_wr_addr,
    input  logic [7:0]          i_wr_data,
    input  logic                i_wr_stb,
    input  logic                i_vid_req,
    input  logic [RAM_BITS-1:0] i_vid_addr,
    output logic [7:0]          o_vid_data,
    output logic                o_vid_valid,
    input  logic                i_clr_req,
    output logic                o_clr_busy,
    output logic                o_wr_overflow,
    output logic [RAM_BITS-1:0] o_mem_addr,
    output logic [7:0]          o_mem_wdata,
    output logic                o_mem_we,
    input  logic [7:0]          i_mem_rdata
);
    import char_ram_pkg::*;
    clr_state_t r_state;
    clr_state_t w_next_state;
    logic [RAM_BITS-1:0] r_clr_addr;
    logic [RAM_BITS-1:0] w_next_clr_addr;
    logic [RAM_BITS+7:0] w_head;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_last;
    logic r_vid_valid;
    logic r_overflow;
    char_wr_fifo #(.W(RAM_BITS + 8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .i_push(i_wr_stb),
        .i_din({i_wr_addr, i_wr_data}),
        .i_pop(w_pop),
        .o_head(w_head),
        .o_empty(w_empty),
        .o_full(w_full)
    );
    assign o_clr_busy = r_state == S_CLEAR;
    assign o_vid_valid = r_vid_valid;
    assign o_vid_data = i_mem_rdata;
    assign o_wr_overflow = r_overflow;
    assign w_last = r_clr_addr == RAM_BITS'(RAM_WORDS - 1);
    // fixed-priority grant: video read, then clear fill, then buffered write
    always_comb begin
        o_mem_we = 1'b0;
        o_mem_addr = '0;
        o_mem_wdata = '0;
        w_pop = 1'b0;
        if (!rst) begin
            if (i_vid_req) begin
                o_mem_addr = i_vid_addr;
            end else if (r_state == S_CLEAR) begin
                o_mem_addr = r_clr_addr;
                o_mem_wdata = FILL_CHAR;
                o_mem_we = 1'b1;
            end else if (!w_empty) begin
                o_mem_addr = w_head[RAM_BITS+7:8];
                o_mem_wdata = w_head[7:0];
                o_mem_we = 1'b1;
                w_pop = 1'b1;
            end
        end
    end
    // clear FSM next state: advance only on cycles the fill wins the RAM
    always_comb begin
        w_next_state = r_state;
        w_next_clr_addr = r_clr_addr;
        if (r_state == S_IDLE) begin
            if (i_clr_req) begin
                w_next_state = S_CLEAR;
                w_next_clr_addr = '0;
            end
        end else if (!i_vid_req) begin
            w_next_state = w_last ? S_IDLE : S_CLEAR;
            w_next_clr_addr = w_last ? '0 : r_clr_addr + 1'b1;
        end
    end
    // clear FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_clr_addr <= '0;
        end else begin
            r_state <= w_next_state;
            r_clr_addr <= w_next_clr_addr;
        end
    end
    // video data valid one cycle after the read request; sticky drop flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vid_valid <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_vid_valid <= i_vid_req;
            if (i_wr_stb && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_char_ram_arbiter.sv
// tb_char_ram_arbiter: directed stimulus checked against a queue-based model every cycle
module tb_char_ram_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic [12:0] wr_addr;
    logic [7:0] wr_data;
    logic wr_stb;
    logic vid_req;
    logic [12:0] vid_addr;
    logic [7:0] vid_data;
    logic vid_valid;
    logic clr_req;
    logic clr_busy;
    logic wr_overflow;
    logic [12:0] mem_addr;
    logic [7:0] mem_wdata;
    logic mem_we;
    logic [7:0] mem_rdata = 8'h00;
    int n_cmp = 0;
    int n_fail = 0;
    always #5 clk = ~clk;
    char_ram_arbiter dut (
        .clk(clk),
        .rst(rst),
        .i_wr_addr(wr_addr),
        .i_wr_data(wr_data),
        .i_wr_stb(wr_stb),
        .i_vid_req(vid_req),
        .i_vid_addr(vid_addr),
        .o_vid_data(vid_data),
        .o_vid_valid(vid_valid),
        .i_clr_req(clr_req),
        .o_clr_busy(clr_busy),
        .o_wr_overflow(wr_overflow),
        .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata),
        .o_mem_we(mem_we),
        .i_mem_rdata(mem_rdata)
    );
    // RAM stand-in: read data is a fixed function of the registered address
    always @(posedge clk) mem_rdata <= mem_addr[7:0] ^ 8'h5A;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    // behavioural model: pending-write queue, clear cursor, overflow flag
    int m_q[$];
    bit m_clr = 0;
    int m_next = 0;
    bit m_ovf = 0;
    bit m_pv = 0;
    int m_pva = 0;
    always @(negedge clk) begin
        bit ewe;
        int ea;
        int ed;
        bit popped;
        ewe = 0;
        ea = 0;
        ed = 0;
        popped = 0;
        if (!rst) begin
            if (vid_req) ea = vid_addr;
            else if (m_clr) begin ewe = 1; ea = m_next; ed = 8'h20; end
            else if (m_q.size() > 0) begin ewe = 1; ea = m_q[0] >> 8; ed = m_q[0] & 8'hFF; popped = 1; end
            chk("mem_addr", 32'(mem_addr), ea);
            if (ewe) chk("mem_wdata", 32'(mem_wdata), ed);
        end
        chk("mem_we", 32'(mem_we), 32'(ewe));
        chk("vid_valid", 32'(vid_valid), 32'(m_pv));
        if (m_pv) chk("vid_data", 32'(vid_data), (m_pva & 8'hFF) ^ 8'h5A);
        chk("clr_busy", 32'(clr_busy), 32'(m_clr));
        chk("wr_overflow", 32'(wr_overflow), 32'(m_ovf));
        if (rst) begin
            m_q.delete();
            m_clr = 0;
            m_next = 0;
            m_ovf = 0;
            m_pv = 0;
        end else begin
            if (popped) void'(m_q.pop_front());
            if (m_clr && !vid_req) begin
                if (m_next == 6399) begin m_clr = 0; m_next = 0; end
                else m_next++;
            end else if (!m_clr && clr_req) begin
                m_clr = 1;
                m_next = 0;
            end
            if (wr_stb) begin
                if (m_q.size() < 4) m_q.push_back((int'(wr_addr) << 8) | int'(wr_data));
                else m_ovf = 1;
            end
            m_pv = vid_req;
            m_pva = vid_addr;
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    initial begin
        int busy;
        int cyc;
        rst = 1; wr_addr = 0; wr_data = 0; wr_stb = 0;
        vid_req = 0; vid_addr = 0; clr_req = 0;
        repeat (3) tick();
        rst = 0;
        repeat (10) tick();
        @(negedge clk);
        chk("idle_we", 32'(mem_we), 0);
        chk("idle_busy", 32'(clr_busy), 0);
        // single write
        tick();
        wr_stb = 1; wr_addr = 13'h0051; wr_data = 8'h41;
        tick();
        wr_stb = 0;
        @(negedge clk);
        chk("wr1_we", 32'(mem_we), 1);
        chk("wr1_addr", 32'(mem_addr), 32'h51);
        chk("wr1_data", 32'(mem_wdata), 32'h41);
        tick();
        @(negedge clk);
        chk("wr1_drained", 32'(mem_we), 0);
        // four writes behind eight video reads
        tick();
        for (int i = 0; i < 8; i++) begin
            vid_req = 1; vid_addr = 13'(12'h100 + i);
            wr_stb = (i < 4); wr_addr = 13'(i + 1); wr_data = 8'(8'h30 + i);
            @(negedge clk);
            chk("vid_blocks_we", 32'(mem_we), 0);
            tick();
        end
        vid_req = 0; wr_stb = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("retire_addr", 32'(mem_addr), k + 1);
            chk("retire_data", 32'(mem_wdata), 32'h30 + k);
            tick();
        end
        // five writes into a four-deep buffer
        for (int i = 0; i < 7; i++) begin
            vid_req = 1; vid_addr = 13'(i * 37);
            wr_stb = (i < 5); wr_addr = 13'(8'h10 + i); wr_data = 8'(8'h60 + i);
            tick();
        end
        vid_req = 0; wr_stb = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("ovf_retire_addr", 32'(mem_addr), 32'h10 + k);
            tick();
        end
        @(negedge clk);
        chk("fifth_dropped", 32'(mem_we), 0);
        chk("ovf_set", 32'(wr_overflow), 1);
        repeat (5) tick();
        @(negedge clk);
        chk("ovf_sticky", 32'(wr_overflow), 1);
        tick();
        rst = 1;
        tick();
        rst = 0;
        @(negedge clk);
        chk("ovf_cleared", 32'(wr_overflow), 0);
        // full clear with an ignored second request and a queued write
        tick();
        clr_req = 1;
        tick();
        clr_req = 0;
        busy = 0;
        cyc = 0;
        while (cyc < 7000) begin
            @(negedge clk);
            if (clr_busy) busy++;
            else break;
            tick();
            cyc++;
            clr_req = (cyc == 100);
            wr_stb = (cyc == 200); wr_addr = 13'h0123; wr_data = 8'h58;
        end
        clr_req = 0; wr_stb = 0;
        chk("clr_cycles", busy, 6400);
        chk("post_clr_we", 32'(mem_we), 1);
        chk("post_clr_addr", 32'(mem_addr), 32'h123);
        chk("post_clr_data", 32'(mem_wdata), 32'h58);
        tick();
        // clear interleaved with reads, then reset mid-fill
        clr_req = 1;
        tick();
        clr_req = 0;
        for (int i = 0; i < 3000; i++) begin
            vid_req = (i % 4 == 0); vid_addr = 13'(i);
            tick();
        end
        @(negedge clk);
        chk("still_clearing", 32'(clr_busy), 1);
        tick();
        vid_req = 0; rst = 1;
        tick();
        tick();
        rst = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("after_rst_we", 32'(mem_we), 0);
            chk("after_rst_busy", 32'(clr_busy), 0);
            tick();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
